// File: rtl/write_port_arbiter_if.sv
// Write-port arbiter bus: per-port packet sources in, single SRAM write stream out.
interface write_port_arbiter_if #(
  parameter int unsigned num_of_ports       = 16,
  parameter int unsigned port_width         = 4,
  parameter int unsigned arbiter_data_width = 64
);
  logic [num_of_ports-1:0]                    req;
  logic [num_of_ports-1:0]                    pkt_vld;
  logic [num_of_ports-1:0]                    pkt_eop;
  logic [num_of_ports*arbiter_data_width-1:0] pkt_data;
  logic                                       sram_ready;
  logic [num_of_ports-1:0]                    gnt;
  logic                                       out_sop;
  logic                                       out_vld;
  logic                                       out_eop;
  logic                                       out_abort;
  logic [arbiter_data_width-1:0]              out_data;
  logic [port_width-1:0]                      out_port;
  logic                                       busy;

  // Packet sources and SRAM writer side
  modport master (
    output req, pkt_vld, pkt_eop, pkt_data, sram_ready,
    input  gnt, out_sop, out_vld, out_eop, out_abort, out_data, out_port, busy
  );

  // Arbiter side
  modport slave (
    input  req, pkt_vld, pkt_eop, pkt_data, sram_ready,
    output gnt, out_sop, out_vld, out_eop, out_abort, out_data, out_port, busy
  );
endinterface

// File: rtl/write_port_arbiter.sv
// Round-robin arbiter granting one port at a time the SRAM write path for a
// whole packet, with a stall timeout that aborts a port that stops sending.
module write_port_arbiter #(
  parameter int unsigned num_of_ports       = 16,
  parameter int unsigned port_width         = 4,
  parameter int unsigned arbiter_data_width = 64,
  parameter int unsigned timeout_cycles     = 255
) (
  input  logic                 clk,
  input  logic                 rst,
  write_port_arbiter_if.slave  bus
);
  localparam int unsigned N       = num_of_ports;
  localparam int unsigned PW      = port_width;
  localparam int unsigned W       = arbiter_data_width;
  localparam logic [7:0]  TIMEOUT = 8'(timeout_cycles);

  typedef enum logic {IDLE, XFER} state_t;

  state_t          r_state,  w_state_nxt;
  logic [N-1:0]    r_gnt,    w_gnt_nxt;
  logic            r_sop,    w_sop_nxt;
  logic            r_vld,    w_vld_nxt;
  logic            r_eop,    w_eop_nxt;
  logic            r_abort,  w_abort_nxt;
  logic [W-1:0]    r_data,   w_data_nxt;
  logic [PW-1:0]   r_port,   w_port_nxt;
  logic [PW-1:0]   r_last,   w_last_nxt;
  logic [7:0]      r_stall,  w_stall_nxt;
  logic            r_first,  w_first_nxt;
  logic            r_busy,   w_busy_nxt;

  logic            w_sel_found;
  logic [PW-1:0]   w_sel;
  logic            w_accept;
  logic [7:0]      w_stall_inc;

  // Round-robin pick: first requester at or after last_grant+1, wrapping
  always_comb begin
    w_sel_found = 1'b0;
    w_sel       = '0;
    for (int unsigned i = 1; i <= N; i++) begin
      if (!w_sel_found && bus.req[PW'(r_last + PW'(i))]) begin
        w_sel_found = 1'b1;
        w_sel       = PW'(r_last + PW'(i));
      end
    end
  end

  assign w_accept    = (r_state == XFER) && bus.pkt_vld[r_port] && bus.sram_ready;
  assign w_stall_inc = r_stall + 8'd1;

  // Next-state and registered-output decode
  always_comb begin
    w_state_nxt = r_state;
    w_gnt_nxt   = r_gnt;
    w_sop_nxt   = 1'b0;
    w_vld_nxt   = 1'b0;
    w_eop_nxt   = 1'b0;
    w_abort_nxt = 1'b0;
    w_data_nxt  = r_data;
    w_port_nxt  = r_port;
    w_last_nxt  = r_last;
    w_stall_nxt = r_stall;
    w_first_nxt = r_first;

    case (r_state)
      IDLE: begin
        w_gnt_nxt = '0;
        if (w_sel_found && bus.sram_ready) begin
          w_state_nxt = XFER;
          w_gnt_nxt   = N'(1) << w_sel;
          w_port_nxt  = w_sel;
          w_last_nxt  = w_sel;
          w_stall_nxt = 8'd0;
          w_first_nxt = 1'b1;
        end
      end
      XFER: begin
        if (w_accept) begin
          w_vld_nxt   = 1'b1;
          w_sop_nxt   = r_first;
          w_eop_nxt   = bus.pkt_eop[r_port];
          w_data_nxt  = bus.pkt_data[r_port*W +: W];
          w_stall_nxt = 8'd0;
          w_first_nxt = 1'b0;
          if (bus.pkt_eop[r_port]) begin
            w_state_nxt = IDLE;
            w_gnt_nxt   = '0;
          end
        end else if (bus.sram_ready) begin
          // Stall only counts while the writer could have taken a beat
          if (w_stall_inc == TIMEOUT) begin
            w_abort_nxt = 1'b1;
            w_state_nxt = IDLE;
            w_gnt_nxt   = '0;
            w_stall_nxt = 8'd0;
          end else begin
            w_stall_nxt = w_stall_inc;
          end
        end
      end
      default: begin
        w_state_nxt = IDLE;
        w_gnt_nxt   = '0;
      end
    endcase

    w_busy_nxt = (w_state_nxt != IDLE);
  end

  // State and output registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= IDLE;
      r_gnt   <= '0;
      r_sop   <= 1'b0;
      r_vld   <= 1'b0;
      r_eop   <= 1'b0;
      r_abort <= 1'b0;
      r_data  <= '0;
      r_port  <= '0;
      r_last  <= PW'(N - 1);
      r_stall <= 8'd0;
      r_first <= 1'b0;
      r_busy  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_gnt   <= w_gnt_nxt;
      r_sop   <= w_sop_nxt;
      r_vld   <= w_vld_nxt;
      r_eop   <= w_eop_nxt;
      r_abort <= w_abort_nxt;
      r_data  <= w_data_nxt;
      r_port  <= w_port_nxt;
      r_last  <= w_last_nxt;
      r_stall <= w_stall_nxt;
      r_first <= w_first_nxt;
      r_busy  <= w_busy_nxt;
    end
  end

  assign bus.gnt       = r_gnt;
  assign bus.out_sop   = r_sop;
  assign bus.out_vld   = r_vld;
  assign bus.out_eop   = r_eop;
  assign bus.out_abort = r_abort;
  assign bus.out_data  = r_data;
  assign bus.out_port  = r_port;
  assign bus.busy      = r_busy;
endmodule

// File: tb/tb_write_port_arbiter.sv
// Bench for write_port_arbiter: directed scenarios plus a randomized run
// against a packet-level reference model.
module tb_write_port_arbiter;
  localparam int unsigned N  = 16;
  localparam int unsigned PW = 4;
  localparam int unsigned W  = 64;

  logic clk;
  logic rst;
  int   n_tests;
  int   n_fail;

  write_port_arbiter_if #(.num_of_ports(N), .port_width(PW), .arbiter_data_width(W)) bus ();
  write_port_arbiter_if #(.num_of_ports(N), .port_width(PW), .arbiter_data_width(W)) bus_to ();

  write_port_arbiter #(
    .num_of_ports(N), .port_width(PW), .arbiter_data_width(W), .timeout_cycles(255)
  ) dut (.clk(clk), .rst(rst), .bus(bus));

  write_port_arbiter #(
    .num_of_ports(N), .port_width(PW), .arbiter_data_width(W), .timeout_cycles(4)
  ) dut_to (.clk(clk), .rst(rst), .bus(bus_to));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic clear_inputs();
    bus.req = '0; bus.pkt_vld = '0; bus.pkt_eop = '0; bus.pkt_data = '0; bus.sram_ready = 1'b0;
    bus_to.req = '0; bus_to.pkt_vld = '0; bus_to.pkt_eop = '0; bus_to.pkt_data = '0;
    bus_to.sram_ready = 1'b0;
  endtask

  task automatic do_reset();
    clear_inputs();
    rst = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b1;
  endtask

  // Reset values of every output
  task automatic test_reset();
    logic [3:0] flags;
    repeat (2) @(negedge clk);
    flags = {bus.out_sop, bus.out_vld, bus.out_eop, bus.out_abort};
    n_tests++; if (bus.gnt !== 16'h0) begin n_fail++; $display("FAIL rst_gnt: got %h want 0000", bus.gnt); end
    n_tests++; if (flags !== 4'b0) begin n_fail++; $display("FAIL rst_flags: got %b want 0000", flags); end
    n_tests++; if (bus.out_data !== 64'h0) begin n_fail++; $display("FAIL rst_data: got %h want 0", bus.out_data); end
    n_tests++; if (bus.out_port !== 4'h0) begin n_fail++; $display("FAIL rst_port: got %h want 0", bus.out_port); end
    n_tests++; if (bus.busy !== 1'b0) begin n_fail++; $display("FAIL rst_busy: got %b want 0", bus.busy); end
    rst = 1'b1;
  endtask

  // Four-beat packet on port 0
  task automatic test_single_port();
    logic [63:0] d;
    do_reset();
    bus.req = 16'h0001; bus.sram_ready = 1'b1;
    tick();
    bus.req = 16'h0000;
    n_tests++; if (bus.gnt !== 16'h0001) begin n_fail++; $display("FAIL sp_gnt: got %h want 0001", bus.gnt); end
    n_tests++; if (bus.busy !== 1'b1) begin n_fail++; $display("FAIL sp_busy: got %b want 1", bus.busy); end
    n_tests++; if (bus.out_port !== 4'd0) begin n_fail++; $display("FAIL sp_port: got %0d want 0", bus.out_port); end
    for (int k = 0; k < 4; k++) begin
      d = 64'hA5A5_0000_0000_0000 + 64'(k);
      bus.pkt_vld[0] = 1'b1; bus.pkt_eop[0] = (k == 3); bus.pkt_data[0 +: W] = d;
      tick();
      n_tests++; if ({bus.out_vld, bus.out_sop, bus.out_eop} !== {1'b1, k == 0, k == 3})
        begin n_fail++; $display("FAIL sp_flags beat %0d: got %b want %b", k, {bus.out_vld, bus.out_sop, bus.out_eop}, {1'b1, k == 0, k == 3}); end
      n_tests++; if (bus.out_data !== d) begin n_fail++; $display("FAIL sp_data beat %0d: got %h want %h", k, bus.out_data, d); end
      n_tests++; if (bus.gnt !== ((k == 3) ? 16'h0000 : 16'h0001))
        begin n_fail++; $display("FAIL sp_gnt beat %0d: got %h", k, bus.gnt); end
    end
    bus.pkt_vld = '0; bus.pkt_eop = '0;
    tick();
    n_tests++; if (bus.out_vld !== 1'b0 || bus.busy !== 1'b0)
      begin n_fail++; $display("FAIL sp_after: vld %b busy %b want 0 0", bus.out_vld, bus.busy); end
  endtask

  // All ports requesting single-beat packets: grants rotate 0..15,0
  task automatic test_round_robin();
    int e;
    logic [3:0] flags;
    do_reset();
    bus.req = 16'hFFFF; bus.sram_ready = 1'b1; bus.pkt_vld = 16'hFFFF; bus.pkt_eop = 16'hFFFF;
    for (int p = 0; p < N; p++) bus.pkt_data[p*W +: W] = 64'hC0DE_0000_0000_0000 + 64'(p);
    for (int i = 0; i < 17; i++) begin
      e = i % N;
      tick();
      n_tests++; if (bus.gnt !== (16'(1) << e) || bus.out_port !== 4'(e))
        begin n_fail++; $display("FAIL rr_gnt %0d: got %h port %0d want port %0d", i, bus.gnt, bus.out_port, e); end
      tick();
      flags = {bus.out_sop, bus.out_vld, bus.out_eop, bus.out_abort};
      n_tests++; if (flags !== 4'b1110) begin n_fail++; $display("FAIL rr_flags %0d: got %b want 1110", i, flags); end
      n_tests++; if (bus.out_data !== 64'hC0DE_0000_0000_0000 + 64'(e))
        begin n_fail++; $display("FAIL rr_data %0d: got %h", i, bus.out_data); end
      n_tests++; if (bus.gnt !== 16'h0) begin n_fail++; $display("FAIL rr_gap %0d: got %h want 0000", i, bus.gnt); end
    end
    clear_inputs();
  endtask

  // Port 5 with sram_ready low for 10 cycles mid-packet
  task automatic test_stall();
    logic [3:0] flags;
    do_reset();
    bus.req = 16'h0020; bus.sram_ready = 1'b1;
    tick();
    bus.req = 16'h0000;
    n_tests++; if (bus.gnt !== 16'h0020) begin n_fail++; $display("FAIL st_gnt: got %h want 0020", bus.gnt); end
    bus.pkt_vld[5] = 1'b1; bus.pkt_data[5*W +: W] = 64'h5555_0000_0000_0000;
    tick();
    n_tests++; if ({bus.out_vld, bus.out_sop} !== 2'b11 || bus.out_data !== 64'h5555_0000_0000_0000)
      begin n_fail++; $display("FAIL st_beat0: vld/sop %b data %h", {bus.out_vld, bus.out_sop}, bus.out_data); end
    bus.pkt_data[5*W +: W] = 64'h5555_0000_0000_0001;
    bus.sram_ready = 1'b0;
    for (int c = 0; c < 10; c++) begin
      bus.pkt_vld = 16'($urandom) | 16'h0020;
      bus.pkt_eop = 16'($urandom) & 16'hFFDF;
      tick();
      flags = {bus.out_sop, bus.out_vld, bus.out_eop, bus.out_abort};
      n_tests++; if (flags !== 4'b0 || bus.gnt !== 16'h0020)
        begin n_fail++; $display("FAIL st_hold %0d: flags %b gnt %h want 0000 0020", c, flags, bus.gnt); end
    end
    bus.sram_ready = 1'b1;
    for (int k = 1; k < 4; k++) begin
      bus.pkt_vld = 16'($urandom) | 16'h0020;
      bus.pkt_eop = (16'($urandom) & 16'hFFDF) | ((k == 3) ? 16'h0020 : 16'h0000);
      bus.pkt_data[5*W +: W] = 64'h5555_0000_0000_0000 + 64'(k);
      tick();
      n_tests++; if ({bus.out_vld, bus.out_sop, bus.out_eop, bus.out_abort} !== {1'b1, 1'b0, k == 3, 1'b0})
        begin n_fail++; $display("FAIL st_flags beat %0d: got %b", k, {bus.out_vld, bus.out_sop, bus.out_eop, bus.out_abort}); end
      n_tests++; if (bus.out_data !== 64'h5555_0000_0000_0000 + 64'(k))
        begin n_fail++; $display("FAIL st_data beat %0d: got %h", k, bus.out_data); end
    end
    n_tests++; if (bus.gnt !== 16'h0) begin n_fail++; $display("FAIL st_end_gnt: got %h want 0000", bus.gnt); end
    clear_inputs();
  endtask

  // timeout_cycles=4, port 3 granted and silent
  task automatic test_timeout();
    logic [3:0] flags;
    do_reset();
    bus_to.req = 16'h0008; bus_to.sram_ready = 1'b1;
    tick();
    bus_to.req = 16'h0000;
    bus_to.pkt_vld = 16'hFFF7;
    n_tests++; if (bus_to.gnt !== 16'h0008) begin n_fail++; $display("FAIL to_gnt: got %h want 0008", bus_to.gnt); end
    for (int c = 1; c <= 4; c++) begin
      tick();
      flags = {bus_to.out_sop, bus_to.out_vld, bus_to.out_eop, bus_to.out_abort};
      if (c < 4) begin
        n_tests++; if (flags !== 4'b0000 || bus_to.gnt !== 16'h0008)
          begin n_fail++; $display("FAIL to_wait %0d: flags %b gnt %h want 0000 0008", c, flags, bus_to.gnt); end
      end else begin
        n_tests++; if (flags !== 4'b0001 || bus_to.gnt !== 16'h0000 || bus_to.busy !== 1'b0)
          begin n_fail++; $display("FAIL to_abort: flags %b gnt %h busy %b want 0001 0000 0", flags, bus_to.gnt, bus_to.busy); end
      end
    end
    bus_to.req = 16'hFFFF;
    tick();
    n_tests++; if (bus_to.gnt !== 16'h0010 || bus_to.out_abort !== 1'b0)
      begin n_fail++; $display("FAIL to_next: gnt %h abort %b want 0010 0", bus_to.gnt, bus_to.out_abort); end
    clear_inputs();
  endtask

  // Async reset during beat 2 of a 6-beat packet
  task automatic test_reset_mid();
    logic [3:0] flags;
    do_reset();
    bus.req = 16'h0001; bus.sram_ready = 1'b1;
    tick();
    bus.req = 16'h0000;
    bus.pkt_vld[0] = 1'b1; bus.pkt_data[0 +: W] = 64'h6666_0000_0000_0000;
    tick();
    bus.pkt_data[0 +: W] = 64'h6666_0000_0000_0001;
    @(posedge clk);
    #2 rst = 1'b0;
    #1;
    flags = {bus.out_sop, bus.out_vld, bus.out_eop, bus.out_abort};
    n_tests++; if (flags !== 4'b0 || bus.gnt !== 16'h0 || bus.busy !== 1'b0)
      begin n_fail++; $display("FAIL rm_now: flags %b gnt %h busy %b want 0000 0000 0", flags, bus.gnt, bus.busy); end
    n_tests++; if (bus.out_data !== 64'h0 || bus.out_port !== 4'h0)
      begin n_fail++; $display("FAIL rm_data: data %h port %0d want 0 0", bus.out_data, bus.out_port); end
    @(negedge clk);
    bus.pkt_vld = '0; bus.req = 16'h8001;
    @(negedge clk);
    rst = 1'b1;
    tick();
    flags = {bus.out_sop, bus.out_vld, bus.out_eop, bus.out_abort};
    n_tests++; if (bus.gnt !== 16'h0001 || flags !== 4'b0)
      begin n_fail++; $display("FAIL rm_regrant: gnt %h flags %b want 0001 0000", bus.gnt, flags); end
    clear_inputs();
  endtask

  // Random traffic checked against a packet-level model
  task automatic test_random();
    logic [N-1:0] m_gnt;
    int           m_port, m_last, m_len, m_beat, m_stall;
    logic [63:0]  m_data [8];
    logic         e_sop, e_vld, e_eop, e_abort;
    logic [63:0]  e_data;
    logic [3:0]   flags;
    int           c;
    do_reset();
    m_gnt = '0; m_port = 0; m_last = N - 1; m_len = 0; m_beat = 0; m_stall = 0;
    e_sop = 0; e_vld = 0; e_eop = 0; e_abort = 0; e_data = '0;
    for (int cyc = 0; cyc < 3000; cyc++) begin
      flags = {bus.out_sop, bus.out_vld, bus.out_eop, bus.out_abort};
      n_tests++; if (bus.gnt !== m_gnt || bus.busy !== (m_gnt != '0))
        begin n_fail++; $display("FAIL rnd_gnt cyc %0d: got %h busy %b want %h", cyc, bus.gnt, bus.busy, m_gnt); end
      n_tests++; if (flags !== {e_sop, e_vld, e_eop, e_abort})
        begin n_fail++; $display("FAIL rnd_flags cyc %0d: got %b want %b", cyc, flags, {e_sop, e_vld, e_eop, e_abort}); end
      if (e_vld) begin
        n_tests++; if (bus.out_data !== e_data)
          begin n_fail++; $display("FAIL rnd_data cyc %0d: got %h want %h", cyc, bus.out_data, e_data); end
      end
      // Drive: noise on every port, the real packet on the granted one
      bus.req = ($urandom_range(0, 3) == 0) ? 16'h0 : (16'($urandom) & 16'($urandom));
      bus.sram_ready = ($urandom_range(0, 3) != 0);
      bus.pkt_vld = 16'($urandom);
      bus.pkt_eop = 16'($urandom);
      for (int p = 0; p < N; p++) bus.pkt_data[p*W +: W] = {$urandom, $urandom};
      if (m_gnt != '0) begin
        bus.pkt_vld[m_port] = ($urandom_range(0, 9) < 7);
        bus.pkt_eop[m_port] = (m_beat == m_len - 1);
        bus.pkt_data[m_port*W +: W] = m_data[m_beat];
      end
      // Model: what the next edge must produce
      e_sop = 0; e_vld = 0; e_eop = 0; e_abort = 0;
      if (m_gnt == '0) begin
        if (bus.req != '0 && bus.sram_ready) begin
          for (int k = 1; k <= N; k++) begin
            c = (m_last + k) % N;
            if (bus.req[c] && m_gnt == '0) begin
              m_port = c; m_last = c; m_gnt = 16'(1) << c;
            end
          end
          m_len = $urandom_range(1, 6); m_beat = 0; m_stall = 0;
          for (int b = 0; b < 8; b++) m_data[b] = {$urandom, $urandom};
        end
      end else if (bus.pkt_vld[m_port] && bus.sram_ready) begin
        e_vld = 1; e_data = m_data[m_beat]; e_sop = (m_beat == 0); e_eop = (m_beat == m_len - 1);
        m_stall = 0; m_beat++;
        if (e_eop) m_gnt = '0;
      end else if (bus.sram_ready) begin
        m_stall++;
        if (m_stall == 255) begin e_abort = 1; m_gnt = '0; m_stall = 0; end
      end
      tick();
    end
    clear_inputs();
  endtask

  initial begin
    n_tests = 0;
    n_fail  = 0;
    rst     = 1'b0;
    clear_inputs();
    test_reset();
    test_single_port();
    test_round_robin();
    test_stall();
    test_timeout();
    test_reset_mid();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/write_port_arbiter.md
WRITE_PORT_ARBITER -- requirements
Module: write_port_arbiter

Interface
REQ-001 SHALL provide parameter num_of_ports, default 16, number of input ports competing for the SRAM write path.
REQ-002 SHALL provide parameter port_width, default 4, index width; num_of_ports = 2^port_width.
REQ-003 SHALL provide parameter arbiter_data_width, default 64, beat width.
REQ-004 SHALL provide parameter timeout_cycles, default 255, stall-beat limit before abort; range 1..255.
REQ-005 SHALL provide port clk, input, 1, sole clock; all flops rise on posedge clk.
REQ-006 SHALL provide port rst, input, 1, asynchronous active-low reset.
REQ-007 SHALL provide port req, input, num_of_ports, per-port "packet pending".
REQ-008 SHALL provide port pkt_vld, input, num_of_ports, per-port beat valid.
REQ-009 SHALL provide port pkt_eop, input, num_of_ports, per-port last beat.
REQ-010 SHALL provide port pkt_data, input, num_of_ports*arbiter_data_width, port p at bits [p*W +: W].
REQ-011 SHALL provide port sram_ready, input, 1, downstream writer accepts a beat this cycle.
REQ-012 SHALL provide port gnt, output, num_of_ports, registered one-hot grant.
REQ-013 SHALL provide ports out_sop, out_vld, out_eop, out_abort, each output, 1, registered.
REQ-014 SHALL provide port out_data, output, arbiter_data_width, registered beat.
REQ-015 SHALL provide port out_port, output, port_width, index of granted port.
REQ-016 SHALL provide port busy, output, 1, high whenever state is not IDLE.

Function
REQ-017 SHALL implement states IDLE and XFER.
REQ-018 IDLE: when |req and sram_ready, SHALL select the first requesting port searching upward from last_grant+1 modulo num_of_ports, then set gnt, out_port, last_grant and enter XFER on the next edge.
REQ-019 IDLE with no req or sram_ready low: SHALL stay in IDLE with gnt=0.
REQ-020 A beat SHALL be accepted when state=XFER, pkt_vld[out_port]=1 and sram_ready=1; the port holds data otherwise.
REQ-021 An accepted beat SHALL appear one cycle later as out_vld=1 with out_data=pkt_data of out_port.
REQ-022 out_sop SHALL be 1 only with the first accepted beat of a grant.
REQ-023 out_eop SHALL equal pkt_eop[out_port] on an accepted beat; a single-beat packet asserts out_sop and out_eop together.
REQ-024 Accepted eop beat: gnt SHALL clear and state SHALL return to IDLE on the same edge; the next grant occurs no earlier than one cycle later.
REQ-025 pkt_vld/pkt_eop of non-granted ports, and req changes during XFER, SHALL be ignored.
REQ-026 An 8-bit stall counter SHALL increment each XFER cycle with sram_ready=1 and no accepted beat, hold when sram_ready=0, and clear on any accepted beat or grant.
REQ-027 When the stall counter reaches timeout_cycles: SHALL pulse out_abort for one cycle, clear gnt, return to IDLE, without asserting out_eop; last_grant is retained.
REQ-028 out_sop, out_vld, out_eop, out_abort SHALL be zero in every cycle without an accepted beat or abort.
REQ-029 Eop acceptance and timeout in the same cycle: the beat SHALL win, with no out_abort.

Reset
REQ-030 rst low SHALL immediately force state=IDLE, gnt=0, out_sop=out_vld=out_eop=out_abort=0, out_data=0, out_port=0, busy=0, stall counter=0, last_grant=num_of_ports-1.
REQ-031 Reset mid-XFER SHALL discard the packet with no out_eop or out_abort; after release, port 0 has first priority.

Verification
REQ-032 Reset release, req=16'h0001, 4-beat packet on port 0 -> gnt=16'h0001 one cycle after req seen; out_sop on beat 1, out_eop on beat 4; gnt clears at eop edge.
REQ-033 req=16'hFFFF held, 1-beat packets -> grants visit ports 0,1,...,15,0 in order; each out_sop=out_eop=1.
REQ-034 Granted port 5, sram_ready low 10 cycles mid-packet -> no out_vld during stall, no abort, data order preserved.
REQ-035 timeout_cycles=4, granted port 3 never asserts pkt_vld, sram_ready=1 -> out_abort pulse 4 cycles after grant, gnt=0, next grant goes to port 4 or higher.
REQ-036 rst asserted during beat 2 of a 6-beat packet -> all outputs 0 immediately; after release with req=16'h8001, port 0 is granted first.
